// File: rtl/eng_pipe_fa_pkg.sv
// Purpose : shared types, widths and the opcode-to-entry-PC mapping for the engine-pipe fetch stage.
// Latency : n/a (types and a combinational helper only).
// Backpr. : n/a.
// Contents: PC_W, OPCODE_W, ENTRY_SHIFT, pc_t, opcode_t, fa_state_t, entry_pc().
package eng_pipe_pkg;

   localparam int PC_W        = 10;
   localparam int OPCODE_W    = 4;
   localparam int ENTRY_SHIFT = 4;

   typedef logic [PC_W-1:0]     pc_t;
   typedef logic [OPCODE_W-1:0] opcode_t;

   typedef enum logic {
      FA_IDLE = 1'b0,
      FA_RUN  = 1'b1
   } fa_state_t;

   // Entry PC is the opcode scaled by 2^ENTRY_SHIFT; bits above PC_W are dropped.
   function automatic pc_t entry_pc(input opcode_t op);
      logic [PC_W+OPCODE_W-1:0] wide;
      wide = {{PC_W{1'b0}}, op} << ENTRY_SHIFT;
      return wide[PC_W-1:0];
   endfunction

endpackage

// File: rtl/eng_pipe_fa_ras.sv
// Purpose : return-address stack (pointer-based LIFO) for microcode call/return.
// Latency : push/pop take effect on the next edge; top_pc is combinational from the pointer.
// Backpr. : none; a push when full or a pop when empty is ignored, the caller flags the error.
// Ports   : clk, srst (sync, active-high), clr (flush), push/push_pc, pop, top_pc, full, empty.
module eng_pipe_fa_ras
   import eng_pipe_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic srst,
   input  logic clr,
   input  logic push,
   input  pc_t  push_pc,
   input  logic pop,
   output pc_t  top_pc,
   output logic full,
   output logic empty
);

   localparam int PW = $clog2(DEPTH + 1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0] ptr;     // number of valid entries
   logic [IW-1:0] top_idx;
   pc_t           mem [DEPTH];

   assign full    = (ptr == PW'(DEPTH));
   assign empty   = (ptr == '0);
   assign top_idx = IW'(ptr - PW'(1));
   assign top_pc  = mem[top_idx];

   always_ff @(posedge clk) begin
      if (srst || clr) begin
         ptr <= '0;
      end else if (push && !full) begin
         mem[ptr[IW-1:0]] <= push_pc;
         ptr              <= ptr + PW'(1);
      end else if (pop && !empty) begin
         ptr <= ptr - PW'(1);
      end
   end

endmodule

// File: rtl/eng_pipe_fa.sv
// Purpose : fetch-stage microcode sequencer; maps command opcodes to entry PCs and steps the PC.
// Latency : command handshake -> first valid PC 1 cycle; redirect/call/ret -> target PC 1 cycle.
// Backpr. : o_cmd_rdy_r is high only in IDLE; i_xa_stall holds the PC, redirect overrides stall.
// Ports   : clk, srst (sync, active-high); cmd vld/opcode/rdy; fa vld/pc; xa stall/redirect/done/call/ret;
//           o_busy_r (in RUN), o_err_r (sticky: PC wrap, RAS overflow/underflow).
// Option  : define ENG_PIPE_FA_RAS_EN to build the return-address stack for call/ret.
module eng_pipe_fa
   import eng_pipe_pkg::*;
#(
   parameter int RAS_DEPTH = 4
) (
   input  logic                clk,
   input  logic                srst,
   input  logic                i_cmd_vld,
   input  logic [OPCODE_W-1:0] i_cmd_opcode,
   output logic                o_cmd_rdy_r,
   output logic                o_fa_vld_r,
   output logic [PC_W-1:0]     o_fa_pc_r,
   input  logic                i_xa_stall,
   input  logic                i_xa_redirect_vld,
   input  logic [PC_W-1:0]     i_xa_redirect_pc,
   input  logic                i_xa_done,
   input  logic                i_xa_call_vld,
   input  logic                i_xa_ret_vld,
   output logic                o_busy_r,
   output logic                o_err_r
);

   fa_state_t state, state_nxt;
   logic      rdy_nxt, vld_nxt, busy_nxt, err_nxt;
   pc_t       pc_nxt;

`ifdef ENG_PIPE_FA_RAS_EN
   logic ras_push, ras_pop, ras_clr, ras_full, ras_empty;
   pc_t  ras_top;

   // The return point pushed is the PC currently presented alongside the call.
   eng_pipe_fa_ras #(.DEPTH(RAS_DEPTH)) u_ras (
      .clk     (clk),
      .srst    (srst),
      .clr     (ras_clr),
      .push    (ras_push),
      .push_pc (o_fa_pc_r),
      .pop     (ras_pop),
      .top_pc  (ras_top),
      .full    (ras_full),
      .empty   (ras_empty)
   );
`else
   logic unused_ras_in;
   assign unused_ras_in = &{1'b0, i_xa_call_vld, i_xa_ret_vld};
`endif

   always_comb begin
      state_nxt = state;
      rdy_nxt   = o_cmd_rdy_r;
      vld_nxt   = o_fa_vld_r;
      pc_nxt    = o_fa_pc_r;
      busy_nxt  = o_busy_r;
      err_nxt   = o_err_r;
`ifdef ENG_PIPE_FA_RAS_EN
      ras_push  = 1'b0;
      ras_pop   = 1'b0;
      ras_clr   = 1'b0;
`endif
      case (state)
         FA_IDLE: begin
            if (i_cmd_vld && o_cmd_rdy_r) begin
               state_nxt = FA_RUN;
               pc_nxt    = entry_pc(i_cmd_opcode);
               vld_nxt   = 1'b1;
               rdy_nxt   = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         FA_RUN: begin
            if (i_xa_done) begin
               // PC is left as-is; only the valid drops.
               state_nxt = FA_IDLE;
               vld_nxt   = 1'b0;
               rdy_nxt   = 1'b1;
               busy_nxt  = 1'b0;
`ifdef ENG_PIPE_FA_RAS_EN
               ras_clr   = 1'b1;
            end else if (i_xa_call_vld) begin
               pc_nxt = i_xa_redirect_pc;
               if (ras_full) err_nxt  = 1'b1;
               else          ras_push = 1'b1;
            end else if (i_xa_ret_vld) begin
               if (ras_empty) begin
                  pc_nxt  = '0;
                  err_nxt = 1'b1;
               end else begin
                  pc_nxt  = ras_top;
                  ras_pop = 1'b1;
               end
`endif
            end else if (i_xa_redirect_vld) begin
               pc_nxt = i_xa_redirect_pc;
            end else if (!i_xa_stall) begin
               // Only a sequential step off the top of the ROM is an error.
               if (&o_fa_pc_r) err_nxt = 1'b1;
               pc_nxt = o_fa_pc_r + pc_t'(1);
            end
         end
         default: state_nxt = FA_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state       <= FA_IDLE;
         o_cmd_rdy_r <= 1'b1;
         o_fa_vld_r  <= 1'b0;
         o_fa_pc_r   <= '0;
         o_busy_r    <= 1'b0;
         o_err_r     <= 1'b0;
      end else begin
         state       <= state_nxt;
         o_cmd_rdy_r <= rdy_nxt;
         o_fa_vld_r  <= vld_nxt;
         o_fa_pc_r   <= pc_nxt;
         o_busy_r    <= busy_nxt;
         o_err_r     <= err_nxt;
      end
   end

endmodule

// File: tb/tb_eng_pipe_fa.sv
// Purpose : self-checking bench for eng_pipe_fa; per-cycle expected outputs queued and compared.
// Latency : each stimulus cycle is checked 1 ns after the following rising edge.
// Backpr. : n/a; all loops are fixed length.
module tb_eng_pipe_fa;

   logic       clk = 1'b0;
   logic       srst;
   logic       i_cmd_vld;
   logic [3:0] i_cmd_opcode;
   logic       o_cmd_rdy_r;
   logic       o_fa_vld_r;
   logic [9:0] o_fa_pc_r;
   logic       i_xa_stall;
   logic       i_xa_redirect_vld;
   logic [9:0] i_xa_redirect_pc;
   logic       i_xa_done;
   logic       i_xa_call_vld;
   logic       i_xa_ret_vld;
   logic       o_busy_r;
   logic       o_err_r;

   always #5 clk = ~clk;

   eng_pipe_fa dut (
      .clk               (clk),
      .srst              (srst),
      .i_cmd_vld         (i_cmd_vld),
      .i_cmd_opcode      (i_cmd_opcode),
      .o_cmd_rdy_r       (o_cmd_rdy_r),
      .o_fa_vld_r        (o_fa_vld_r),
      .o_fa_pc_r         (o_fa_pc_r),
      .i_xa_stall        (i_xa_stall),
      .i_xa_redirect_vld (i_xa_redirect_vld),
      .i_xa_redirect_pc  (i_xa_redirect_pc),
      .i_xa_done         (i_xa_done),
      .i_xa_call_vld     (i_xa_call_vld),
      .i_xa_ret_vld      (i_xa_ret_vld),
      .o_busy_r          (o_busy_r),
      .o_err_r           (o_err_r)
   );

   typedef struct {
      logic       vld;
      logic [9:0] pc;
      logic       rdy;
      logic       busy;
      logic       err;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference state
   logic       m_run = 1'b0;
   logic       m_rdy = 1'b1;
   logic       m_vld = 1'b0;
   logic [9:0] m_pc  = '0;
   logic       m_busy = 1'b0;
   logic       m_err  = 1'b0;
   logic [9:0] m_stk[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic cv, input logic [3:0] op, input logic st,
                       input logic rv, input logic [9:0] rpc, input logic dn,
                       input logic cl, input logic rt);
      exp_t e;
      exp_t g;
      srst = rst; i_cmd_vld = cv; i_cmd_opcode = op; i_xa_stall = st;
      i_xa_redirect_vld = rv; i_xa_redirect_pc = rpc; i_xa_done = dn;
      i_xa_call_vld = cl; i_xa_ret_vld = rt;
      if (rst) begin
         m_run = 0; m_rdy = 1; m_vld = 0; m_pc = '0; m_busy = 0; m_err = 0;
         m_stk.delete();
      end else if (!m_run) begin
         if (cv && m_rdy) begin
            m_run = 1; m_pc = {2'b00, op, 4'h0}; m_vld = 1; m_rdy = 0; m_busy = 1;
         end
      end else if (dn) begin
         m_run = 0; m_vld = 0; m_rdy = 1; m_busy = 0;
         m_stk.delete();
`ifdef ENG_PIPE_FA_RAS_EN
      end else if (cl) begin
         if (m_stk.size() >= 4) m_err = 1;
         else m_stk.push_back(m_pc);
         m_pc = rpc;
      end else if (rt) begin
         if (m_stk.size() == 0) begin
            m_pc = '0; m_err = 1;
         end else begin
            m_pc = m_stk.pop_back();
         end
`endif
      end else if (rv) begin
         m_pc = rpc;
      end else if (!st) begin
         if (m_pc == 10'h3FF) m_err = 1;
         m_pc = m_pc + 10'd1;
      end
      e.vld = m_vld; e.pc = m_pc; e.rdy = m_rdy; e.busy = m_busy; e.err = m_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk("vld",  {31'd0, o_fa_vld_r},  {31'd0, g.vld});
      chk("pc",   {22'd0, o_fa_pc_r},   {22'd0, g.pc});
      chk("rdy",  {31'd0, o_cmd_rdy_r}, {31'd0, g.rdy});
      chk("busy", {31'd0, o_busy_r},    {31'd0, g.busy});
      chk("err",  {31'd0, o_err_r},     {31'd0, g.err});
   endtask

   task automatic nop();
      step(0, 0, 4'h0, 0, 0, 10'h0, 0, 0, 0);
   endtask

   initial begin
      srst = 1; i_cmd_vld = 0; i_cmd_opcode = '0; i_xa_stall = 0; i_xa_redirect_vld = 0;
      i_xa_redirect_pc = '0; i_xa_done = 0; i_xa_call_vld = 0; i_xa_ret_vld = 0;

      // Reset state
      step(1, 0, 4'h0, 0, 0, 10'h0, 0, 0, 0);
      step(1, 0, 4'h0, 0, 0, 10'h0, 0, 0, 0);
      chk("rst_rdy", {31'd0, o_cmd_rdy_r}, 32'd1);
      chk("rst_vld", {31'd0, o_fa_vld_r}, 32'd0);

      // Execute-stage inputs are ignored in IDLE
      step(0, 0, 4'h0, 1, 1, 10'h155, 1, 1, 1);

      // Opcode 3 -> 0x030, then stepping and a 2-cycle stall on 0x031
      step(0, 1, 4'h3, 0, 0, 10'h0, 0, 0, 0);
      chk("tp1_pc", {22'd0, o_fa_pc_r}, 32'h030);
      nop();
      step(0, 0, 4'h0, 1, 0, 10'h0, 0, 0, 0);
      step(0, 0, 4'h0, 1, 0, 10'h0, 0, 0, 0);
      chk("tp2_hold", {22'd0, o_fa_pc_r}, 32'h031);
      nop();
      chk("tp2_next", {22'd0, o_fa_pc_r}, 32'h032);
      nop();
      // Redirect with stall: redirect wins
      step(0, 0, 4'h0, 1, 1, 10'h200, 0, 0, 0);
      chk("tp3_redir", {22'd0, o_fa_pc_r}, 32'h200);
      nop();
      step(0, 0, 4'h0, 0, 1, 10'h034, 0, 0, 0);
      // Done with a command already pending: not accepted that cycle
      step(0, 1, 4'h5, 0, 0, 10'h0, 1, 0, 0);
      chk("tp4_rdy", {31'd0, o_cmd_rdy_r}, 32'd1);
      chk("tp4_pc_hold", {22'd0, o_fa_pc_r}, 32'h034);
      step(0, 1, 4'h5, 0, 0, 10'h0, 0, 0, 0);
      chk("tp4_entry", {22'd0, o_fa_pc_r}, 32'h050);
      // Wrap from 0x3FF sets sticky error
      step(0, 0, 4'h0, 0, 1, 10'h3FF, 0, 0, 0);
      nop();
      chk("tp5_wrap_pc", {22'd0, o_fa_pc_r}, 32'h000);
      chk("tp5_err", {31'd0, o_err_r}, 32'd1);
      step(0, 0, 4'h0, 0, 0, 10'h0, 1, 0, 0);
      step(0, 1, 4'hF, 0, 0, 10'h0, 0, 0, 0);
      chk("tp5_sticky", {31'd0, o_err_r}, 32'd1);
      chk("entry_f", {22'd0, o_fa_pc_r}, 32'h0F0);
      // srst mid-RUN, then a redirect to 0 does not flag an error
      step(1, 0, 4'h0, 0, 0, 10'h0, 0, 0, 0);
      chk("srst_vld", {31'd0, o_fa_vld_r}, 32'd0);
      step(0, 1, 4'h1, 0, 0, 10'h0, 0, 0, 0);
      step(0, 0, 4'h0, 0, 1, 10'h000, 0, 0, 0);
      nop();
      chk("tp5_redir0_err", {31'd0, o_err_r}, 32'd0);

`ifdef ENG_PIPE_FA_RAS_EN
      step(1, 0, 4'h0, 0, 0, 10'h0, 0, 0, 0);
      step(0, 1, 4'h4, 0, 0, 10'h0, 0, 0, 0);
      nop();
      step(0, 0, 4'h0, 0, 0, 10'h100, 0, 1, 0);
      chk("tp6_call", {22'd0, o_fa_pc_r}, 32'h100);
      nop();
      step(0, 0, 4'h0, 0, 0, 10'h0, 0, 0, 1);
      chk("tp6_ret", {22'd0, o_fa_pc_r}, 32'h041);
      for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 0, 0, 10'h200 + 10'(i), 0, 1, 0);
      chk("tp6_ovf_err", {31'd0, o_err_r}, 32'd1);
      for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 0, 0, 10'h0, 0, 0, 1);
      step(1, 0, 4'h0, 0, 0, 10'h0, 0, 0, 0);
      step(0, 1, 4'h2, 0, 0, 10'h0, 0, 0, 0);
      step(0, 0, 4'h0, 0, 0, 10'h0, 0, 0, 1);
      chk("tp6_unf_pc", {22'd0, o_fa_pc_r}, 32'h000);
      step(0, 0, 4'h0, 0, 0, 10'h300, 0, 1, 0);
      step(1, 0, 4'h0, 0, 0, 10'h0, 0, 0, 0);
      chk("tp6_srst_rdy", {31'd0, o_cmd_rdy_r}, 32'd1);
      chk("tp6_srst_vld", {31'd0, o_fa_vld_r}, 32'd0);
`endif

      // Random traffic against the reference
      for (int i = 0; i < 600; i++) begin
         logic [9:0] rpc;
         rpc = ($urandom_range(0, 3) == 0) ? 10'h3FE + 10'($urandom_range(0, 2)) : 10'($urandom);
         step($urandom_range(0, 60) == 0,
              $urandom_range(0, 1) == 1,
              4'($urandom),
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 6) == 0,
              rpc,
              $urandom_range(0, 14) == 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
